// File: rtl/cp0_vic.sv
// cp0_vic: coprocessor-0 with N_IRQ edge-detected interrupt lines.
// Each line has its own mask bit. Line 0 has the highest priority. Entry jumps
// to a per-line vector inside the handler base (EHBR).
// Jump interface: jump_en is a one-cycle request. jump_addr is meaningful only
// while jump_en=1. The PC logic must accept it in that cycle; there is no
// back-pressure, and the cycle is gated earlier through ir_en.
module cp0_vic #(
    parameter int N_IRQ       = 4,
    parameter int VEC_SHIFT   = 4,
    parameter int ADDR_STATUS = 12,
    parameter int ADDR_CAUSE  = 13,
    parameter int ADDR_EPC    = 14,
    parameter int ADDR_EHBR   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr,
    output logic             irq_taken
);

    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ERET  = 2'b10;
    localparam logic [4:0] A_STATUS = 5'(ADDR_STATUS);
    localparam logic [4:0] A_CAUSE  = 5'(ADDR_CAUSE);
    localparam logic [4:0] A_EPC    = 5'(ADDR_EPC);
    localparam logic [4:0] A_EHBR   = 5'(ADDR_EHBR);

    logic             ie;
    logic             exl;
    logic [N_IRQ-1:0] im;
    logic [N_IRQ-1:0] ip;
    logic [N_IRQ-1:0] irq_prev;
    logic [4:0]       code;
    logic [31:0]      epc;
    logic [31:0]      ehbr;

    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] masked;
    logic [N_IRQ-1:0] clr_taken;
    logic [N_IRQ-1:0] cause_w1c;
    logic [N_IRQ-1:0] ip_next;
    logic [4:0]       sel_id;
    logic [31:0]      vec_off;
    logic             req;
    logic             op_ok;
    logic             do_store;
    logic             do_eret;

    assign irq_edge = irq_in & ~irq_prev;
    assign masked   = ip & im;
    assign req      = ir_en & ie & ~exl & (|masked);
    // An entry in the same cycle swallows whatever operation was presented.
    assign op_ok    = ir_en & ~req;
    assign do_store = op_ok && (oper == OP_STORE);
    assign do_eret  = op_ok && (oper == OP_ERET);
    assign vec_off  = 32'(sel_id) << VEC_SHIFT;

    // Fixed priority: lowest-numbered pending and unmasked line wins.
    always_comb begin
        sel_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) sel_id = 5'(i);
        end
    end

    // Pending update: a fresh edge always beats a clear in the same cycle.
    always_comb begin
        clr_taken = req ? (N_IRQ'(1) << sel_id) : '0;
        cause_w1c = (do_store && addr_w == A_CAUSE) ? data_w[8 +: N_IRQ] : '0;
        ip_next   = (ip & ~(clr_taken | cause_w1c)) | irq_edge;
    end

    // Read port: shows the current register state, so a store becomes visible the next cycle.
    always_comb begin
        data_r = '0;
        if (addr_r == A_STATUS) begin
            data_r[0]          = ie;
            data_r[1]          = exl;
            data_r[8 +: N_IRQ] = im;
        end else if (addr_r == A_CAUSE) begin
            data_r[8 +: N_IRQ] = ip;
            data_r[6:2]        = code;
        end else if (addr_r == A_EPC) begin
            data_r = epc;
        end else if (addr_r == A_EHBR) begin
            data_r = ehbr;
        end
    end

    // Edge history and pending bits. Capture runs regardless of ir_en and the masks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            ip       <= '0;
        end else begin
            irq_prev <= irq_in;
            ip       <= ip_next;
        end
    end

    // Architectural registers: an entry has priority over a store or an ERET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie   <= 1'b0;
            exl  <= 1'b0;
            im   <= '0;
            code <= '0;
            epc  <= '0;
            ehbr <= '0;
        end else if (req) begin
            epc  <= ret_addr;
            exl  <= 1'b1;
            code <= sel_id;
        end else if (do_store) begin
            if (addr_w == A_STATUS) begin
                ie  <= data_w[0];
                exl <= data_w[1];
                im  <= data_w[8 +: N_IRQ];
            end else if (addr_w == A_EPC) begin
                epc <= data_w;
            end else if (addr_w == A_EHBR) begin
                ehbr <= data_w;
            end
        end else if (do_eret) begin
            exl <= 1'b0;
        end
    end

    // Jump request pulses. jump_addr keeps its last target between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_en   <= 1'b0;
            irq_taken <= 1'b0;
            jump_addr <= '0;
        end else begin
            jump_en   <= req | do_eret;
            irq_taken <= req;
            if (req) begin
                jump_addr <= ehbr + vec_off;
            end else if (do_eret) begin
                jump_addr <= epc;
            end
        end
    end

endmodule

// File: tb/tb_cp0_vic.sv
// Directed bench for cp0_vic: one task per scenario, each with its own inline checks.
module tb_cp0_vic;
  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;
  localparam logic [4:0] A_EHBR   = 5'd15;

  logic        clk;
  logic        rst_n;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic        ir_en;
  logic [3:0]  irq_in;
  logic [31:0] ret_addr;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        irq_taken;

  int errors = 0;
  int checks = 0;
  logic [31:0] v;

  cp0_vic #(.N_IRQ(4), .VEC_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .irq_in(irq_in),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .irq_taken(irq_taken)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    oper = 2'b01; addr_w = a; data_w = d;
    tick();
    oper = 2'b00;
  endtask

  task automatic eret();
    oper = 2'b10;
    tick();
    oper = 2'b00;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    addr_r = a;
    #1;
    val = data_r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; oper = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
    ir_en = 1'b1; irq_in = '0; ret_addr = '0;
    tick(); tick();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rst_jump_en got=%0h exp=0", jump_en); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL rst_irq_taken got=%0h exp=0", irq_taken); end
    checks++; if (jump_addr !== 32'h0) begin errors++; $display("FAIL rst_jump_addr got=%h exp=0", jump_addr); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=0", v); end
    rd(A_CAUSE, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_cause got=%h exp=0", v); end
    rd(A_EPC, v);    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=0", v); end
    rd(A_EHBR, v);   checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_ehbr got=%h exp=0", v); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vector_entry();
    // store/read hazard on EHBR
    oper = 2'b01; addr_w = A_EHBR; data_w = 32'h1000; addr_r = A_EHBR;
    #1;
    checks++; if (data_r !== 32'h0) begin errors++; $display("FAIL hazard_old got=%h exp=0", data_r); end
    tick();
    oper = 2'b00;
    checks++; if (data_r !== 32'h1000) begin errors++; $display("FAIL hazard_new got=%h exp=1000", data_r); end
    mtc0(A_STATUS, 32'h0301);
    ret_addr = 32'h40; irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL t1_jump_en got=%0h exp=1", jump_en); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL t1_irq_taken got=%0h exp=1", irq_taken); end
    checks++; if (jump_addr !== 32'h1010) begin errors++; $display("FAIL t1_jump_addr got=%h exp=1010", jump_addr); end
    rd(A_EPC, v);    checks++; if (v !== 32'h40) begin errors++; $display("FAIL t1_epc got=%h exp=40", v); end
    rd(A_CAUSE, v);  checks++; if (v !== 32'h04) begin errors++; $display("FAIL t1_cause got=%h exp=4", v); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0303) begin errors++; $display("FAIL t1_status got=%h exp=303", v); end
    tick();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL t1_pulse_en got=%0h exp=0", jump_en); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL t1_pulse_taken got=%0h exp=0", irq_taken); end
    checks++; if (jump_addr !== 32'h1010) begin errors++; $display("FAIL t1_addr_hold got=%h exp=1010", jump_addr); end
    eret();
    checks++; if (jump_en !== 1'b1) begin errors++; $display("FAIL t1_eret_en got=%0h exp=1", jump_en); end
    checks++; if (jump_addr !== 32'h40) begin errors++; $display("FAIL t1_eret_addr got=%h exp=40", jump_addr); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL t1_eret_taken got=%0h exp=0", irq_taken); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0301) begin errors++; $display("FAIL t1_eret_status got=%h exp=301", v); end
  endtask

  task automatic test_priority();
    mtc0(A_STATUS, 32'h0701);
    ret_addr = 32'h80; irq_in = 4'b0101;
    tick();
    irq_in = 4'b0000;
    tick();
    checks++; if (jump_addr !== 32'h1000) begin errors++; $display("FAIL prio_addr0 got=%h exp=1000", jump_addr); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL prio_taken0 got=%0h exp=1", irq_taken); end
    rd(A_CAUSE, v); checks++; if (v !== 32'h400) begin errors++; $display("FAIL prio_cause0 got=%h exp=400", v); end
    ret_addr = 32'h84;
    eret();
    checks++; if (jump_addr !== 32'h80) begin errors++; $display("FAIL prio_eret_addr got=%h exp=80", jump_addr); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL prio_eret_taken got=%0h exp=0", irq_taken); end
    tick();
    checks++; if (jump_addr !== 32'h1020) begin errors++; $display("FAIL prio_addr2 got=%h exp=1020", jump_addr); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL prio_taken2 got=%0h exp=1", irq_taken); end
    rd(A_CAUSE, v); checks++; if (v !== 32'h08) begin errors++; $display("FAIL prio_cause2 got=%h exp=8", v); end
    rd(A_EPC, v);   checks++; if (v !== 32'h84) begin errors++; $display("FAIL prio_epc2 got=%h exp=84", v); end
    eret();
    checks++; if (jump_addr !== 32'h84) begin errors++; $display("FAIL prio_eret2 got=%h exp=84", jump_addr); end
  endtask

  task automatic test_nesting();
    mtc0(A_STATUS, 32'h0F01);
    ret_addr = 32'h200; irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL nest_blocked got=%0h exp=0", jump_en); end
    rd(A_CAUSE, v); checks++; if (v !== 32'h800) begin errors++; $display("FAIL nest_cause got=%h exp=800", v); end
    ret_addr = 32'h300;
    eret();
    checks++; if (jump_addr !== 32'h200) begin errors++; $display("FAIL nest_eret_addr got=%h exp=200", jump_addr); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL nest_eret_taken got=%0h exp=0", irq_taken); end
    tick();
    checks++; if (jump_addr !== 32'h1030) begin errors++; $display("FAIL nest_addr3 got=%h exp=1030", jump_addr); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL nest_taken3 got=%0h exp=1", irq_taken); end
    eret();
    checks++; if (jump_addr !== 32'h300) begin errors++; $display("FAIL nest_eret3 got=%h exp=300", jump_addr); end
  endtask

  task automatic test_level_w1c();
    mtc0(A_STATUS, 32'h0E01);
    irq_in = 4'b0001;
    repeat (10) tick();
    rd(A_CAUSE, v); checks++; if (v !== 32'h10C) begin errors++; $display("FAIL lvl_cause got=%h exp=10c", v); end
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL lvl_no_jump got=%0h exp=0", jump_en); end
    mtc0(A_CAUSE, 32'h100);
    rd(A_CAUSE, v); checks++; if (v !== 32'h0C) begin errors++; $display("FAIL w1c_clear got=%h exp=c", v); end
    tick();
    rd(A_CAUSE, v); checks++; if (v !== 32'h0C) begin errors++; $display("FAIL lvl_once got=%h exp=c", v); end
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0001;
    mtc0(A_CAUSE, 32'h100);
    rd(A_CAUSE, v); checks++; if (v !== 32'h10C) begin errors++; $display("FAIL edge_wins got=%h exp=10c", v); end
    irq_in = 4'b0000;
    mtc0(A_CAUSE, 32'h100);
    rd(A_CAUSE, v); checks++; if (v !== 32'h0C) begin errors++; $display("FAIL w1c_again got=%h exp=c", v); end
    mtc0(A_STATUS, 32'h0F01);
    tick(); tick();
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL im_no_entry got=%0h exp=0", jump_en); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0F01) begin errors++; $display("FAIL im_status got=%h exp=f01", v); end
  endtask

  task automatic test_entry_vs_store();
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    oper = 2'b01; addr_w = A_EHBR; data_w = 32'h5000; ret_addr = 32'h500;
    tick();
    oper = 2'b00;
    checks++; if (jump_addr !== 32'h1010) begin errors++; $display("FAIL evs_addr got=%h exp=1010", jump_addr); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL evs_taken got=%0h exp=1", irq_taken); end
    rd(A_EHBR, v); checks++; if (v !== 32'h1000) begin errors++; $display("FAIL evs_ehbr got=%h exp=1000", v); end
    eret();
    checks++; if (jump_addr !== 32'h500) begin errors++; $display("FAIL evs_eret got=%h exp=500", jump_addr); end
  endtask

  task automatic test_ir_en_gate();
    ir_en = 1'b0; irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000; oper = 2'b10;
    tick(); tick();
    oper = 2'b00;
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL gate_no_jump got=%0h exp=0", jump_en); end
    rd(A_CAUSE, v);  checks++; if (v !== 32'h404) begin errors++; $display("FAIL gate_cause got=%h exp=404", v); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0F01) begin errors++; $display("FAIL gate_status got=%h exp=f01", v); end
    ret_addr = 32'h600; ir_en = 1'b1;
    tick();
    checks++; if (jump_addr !== 32'h1020) begin errors++; $display("FAIL gate_addr got=%h exp=1020", jump_addr); end
    checks++; if (irq_taken !== 1'b1) begin errors++; $display("FAIL gate_taken got=%0h exp=1", irq_taken); end
  endtask

  task automatic test_reset_mid();
    irq_in = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rmid_jump_en got=%0h exp=0", jump_en); end
    checks++; if (irq_taken !== 1'b0) begin errors++; $display("FAIL rmid_taken got=%0h exp=0", irq_taken); end
    checks++; if (jump_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", jump_addr); end
    rd(A_STATUS, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmid_status got=%h exp=0", v); end
    rd(A_CAUSE, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmid_cause got=%h exp=0", v); end
    rd(A_EPC, v);    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmid_epc got=%h exp=0", v); end
    tick();
    rst_n = 1'b1;
    tick();
    rd(A_CAUSE, v); checks++; if (v !== 32'h100) begin errors++; $display("FAIL rmid_new_edge got=%h exp=100", v); end
    checks++; if (jump_en !== 1'b0) begin errors++; $display("FAIL rmid_no_entry got=%0h exp=0", jump_en); end
  endtask

  initial begin
    test_reset();
    test_vector_entry();
    test_priority();
    test_nesting();
    test_level_w1c();
    test_entry_vs_store();
    test_ir_en_gate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_vic.md
Name: cp0_vic

Overview:
- Parametrised successor to the single-line CP0 block: a coprocessor-0 with N_IRQ edge-detected interrupt lines, per-line mask, fixed priority and vectored handler entry.
- Sits beside the pipeline. CP0 reads happen in ID, writes and ERET in EXE. On interrupt entry or ERET it drives a one-cycle jump request to the PC logic.

Parameters:
- N_IRQ, 4, number of interrupt lines (1..8).
- VEC_SHIFT, 4, log2 of byte spacing between handler vectors.
- ADDR_STATUS, 12, CP0 address of STATUS.
- ADDR_CAUSE, 13, CP0 address of CAUSE.
- ADDR_EPC, 14, CP0 address of EPC.
- ADDR_EHBR, 15, CP0 address of the handler base register.

Ports:
- clk  in  1  main clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- oper  in  2  CP0 op: 00 none, 01 store (MTC0), 10 ERET, 11 reserved (treated as none).
- addr_r  in  5  read address.
- data_r  out  32  read data, combinational from current register state.
- addr_w  in  5  write address.
- data_w  in  32  write data.
- ir_en  in  1  pipeline may accept interrupt/CP0 op this cycle (stall gate).
- irq_in  in  N_IRQ  synchronous interrupt request lines.
- ret_addr  in  32  address stored to EPC on entry.
- jump_en  out  1  one-cycle jump request.
- jump_addr  out  32  jump target, valid while jump_en=1.
- irq_taken  out  1  one-cycle pulse, coincident with jump_en, on interrupt entry only.

Behaviour:
- Registers (unused bits read 0, writes ignored):
  - STATUS: bit0 IE, bit1 EXL, bits[8+N_IRQ-1:8] IM.
  - CAUSE: bits[8+N_IRQ-1:8] IP (pending), bits[6:2] CODE (id of last taken line).
  - EPC: 32-bit.
  - EHBR: 32-bit.
- Any other address reads 0; stores to it are ignored.
- Reset (rst_n=0, async):
  - All registers 0; irq_in edge history 0.
  - jump_en=0, jump_addr=0, irq_taken=0.
- Pending capture:
  - irq_prev registers irq_in each cycle.
  - IP[i] sets when irq_in[i]=1 and irq_prev[i]=0; a held level sets IP only once.
  - Capture is independent of ir_en, IE, EXL and IM.
- Pending clear:
  - IP[i] clears when line i is taken.
  - IP[i] also clears on a store to CAUSE with data_w[8+i]=1 (write-1-to-clear).
  - A new edge in the same cycle as a clear wins: IP stays 1.
- Request: req = ir_en & IE & ~EXL & |(IP & IM).
- Selected id = lowest index i with IP[i]&IM[i] set (index 0 highest priority).
- Interrupt entry, on the posedge where req=1:
  - EPC <= ret_addr; EXL <= 1; CODE <= id; IP[id] <= 0.
  - Next cycle: jump_en=1, irq_taken=1, jump_addr = EHBR + (id << VEC_SHIFT), 32-bit wrap-around.
  - Any oper in the same cycle is discarded.
- Operations apply only when ir_en=1 and req=0:
  - store: the addressed register is updated at posedge. CAUSE stores affect IP (W1C) only; CODE is read-only.
  - ERET: EXL <= 0; next cycle jump_en=1, jump_addr = EPC. ERET with EXL=0 still jumps to EPC.
- ir_en=0: no op, no entry. Pending capture continues.
- jump_en and irq_taken are single-cycle pulses, deasserted the following cycle unless a new event occurs. jump_addr holds its last value.
- Nesting: EXL blocks re-entry until ERET. Software may re-enable by clearing EXL via a STATUS store.
- Store/read hazard: data_r shows the pre-write value in the write cycle and the new value from the next cycle.
- Reset mid-handler: EXL, IP and EPC clear, any pending jump is cancelled, and the edge history clears. A line held high through reset therefore registers a new edge after release.

Test Plan:
- Set EHBR=0x1000 and STATUS=0x0301 (IE, IM0..1). Pulse irq_in[1] with ret_addr=0x40 -> one cycle later jump_en=1, irq_taken=1, jump_addr=0x1010; EPC=0x40; CODE=1; EXL=1; IP[1]=0.
- Raise irq_in[0] and irq_in[2] simultaneously with IM=0x7 -> line 0 taken (jump_addr=EHBR+0x00). IP[2] stays set; after ERET, line 2 is taken (jump_addr=EHBR+0x20).
- While EXL=1, pulse irq_in[3] with IM[3]=1 -> no jump and IP[3]=1. Issue ERET -> jump_addr=EPC. On the next cycle line 3 is taken.
- Hold irq_in[0] high for 10 cycles with IM0=0 -> IP[0]=1 only. Store CAUSE data_w=0x100 -> IP[0]=0. Set IM0 -> no entry.
- Set req=1 and oper=store to EHBR in the same cycle -> entry uses the old EHBR and the store is dropped. With ir_en=0 and req-worthy state -> no entry until ir_en=1.
- Assert rst_n=0 asynchronously mid-cycle right after entry -> jump_en=0 immediately; STATUS, CAUSE and EPC all read 0.
